axi4_lite_master: RTL and testbench

AXI4-Lite initiator that converts a simple single-command request/response interface into AXI4-Lite read and write transactions. It sits on the control/CPU side of the bus, facing the team's AXI4-Lite slave blocks. It keeps at most one transaction outstanding, issues AW and W concurrently, and returns the response data and status on a one-cycle response strobe.

---
 rtl/axi4_lite_master.sv | 157 +++++++++++++++
 tb/tb_axi4_lite_master.sv | 353 +++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/axi4_lite_master.sv
// AXI4-Lite initiator. A single-command request/response port is turned into
// AXI4-Lite read or write transactions, with at most one transaction in
// flight. AW and W are issued together and complete independently; the result
// comes back on a one-cycle response strobe, and the response fields then hold
// until the next response.
//
// state        | meaning
// -------------+----------------------------------------------------------
// IDLE         | no transaction in flight, cmd_ready high
// WR_ADDR_DATA | AW and/or W still waiting for their handshakes
// WR_RESP      | both write handshakes done, BREADY high, waiting on BVALID
// RD_ADDR      | ARVALID high, waiting on ARREADY
// RD_DATA      | RREADY high, waiting on RVALID
module axi4_lite_master #(
    parameter int DATA_WIDTH    = 32,
    parameter int ADDRESS_WIDTH = 32
) (
    input  logic                      ACLK,
    input  logic                      ARESETn,

    input  logic                      cmd_valid,
    output logic                      cmd_ready,
    input  logic                      cmd_write,
    input  logic [ADDRESS_WIDTH-1:0]  cmd_addr,
    input  logic [DATA_WIDTH-1:0]     cmd_wdata,
    input  logic [DATA_WIDTH/8-1:0]   cmd_wstrb,

    output logic                      rsp_valid,
    output logic                      rsp_write,
    output logic [DATA_WIDTH-1:0]     rsp_rdata,
    output logic [1:0]                rsp_resp,

    output logic [ADDRESS_WIDTH-1:0]  AWADDR,
    output logic                      AWVALID,
    input  logic                      AWREADY,
    output logic [DATA_WIDTH-1:0]     WDATA,
    output logic [DATA_WIDTH/8-1:0]   WSTRB,
    output logic                      WVALID,
    input  logic                      WREADY,
    input  logic [1:0]                BRESP,
    input  logic                      BVALID,
    output logic                      BREADY,
    output logic [ADDRESS_WIDTH-1:0]  ARADDR,
    output logic                      ARVALID,
    input  logic                      ARREADY,
    input  logic [DATA_WIDTH-1:0]     RDATA,
    input  logic [1:0]                RRESP,
    input  logic                      RVALID,
    output logic                      RREADY
);

    typedef enum logic [2:0] {
        IDLE,
        WR_ADDR_DATA,
        WR_RESP,
        RD_ADDR,
        RD_DATA
    } state_t;

    state_t state;

    // A command is only taken when nothing is in flight.
    assign cmd_ready = (state == IDLE);

    // Transaction sequencer: state, registered AXI controls and response capture.
    always_ff @(posedge ACLK or negedge ARESETn) begin
        if (!ARESETn) begin
            state     <= IDLE;
            AWADDR    <= '0;
            AWVALID   <= 1'b0;
            WDATA     <= '0;
            WSTRB     <= '0;
            WVALID    <= 1'b0;
            BREADY    <= 1'b0;
            ARADDR    <= '0;
            ARVALID   <= 1'b0;
            RREADY    <= 1'b0;
            rsp_valid <= 1'b0;
            rsp_write <= 1'b0;
            rsp_rdata <= '0;
            rsp_resp  <= 2'b00;
        end else begin
            // The strobe is a single cycle; the response fields themselves hold.
            rsp_valid <= 1'b0;

            case (state)
                IDLE: begin
                    if (cmd_valid) begin
                        if (cmd_write) begin
                            AWADDR  <= cmd_addr;
                            WDATA   <= cmd_wdata;
                            WSTRB   <= cmd_wstrb;
                            AWVALID <= 1'b1;
                            WVALID  <= 1'b1;
                            state   <= WR_ADDR_DATA;
                        end else begin
                            ARADDR  <= cmd_addr;
                            ARVALID <= 1'b1;
                            state   <= RD_ADDR;
                        end
                    end
                end

                WR_ADDR_DATA: begin
                    if (AWVALID && AWREADY) begin
                        AWVALID <= 1'b0;
                    end
                    if (WVALID && WREADY) begin
                        WVALID <= 1'b0;
                    end
                    // A channel whose VALID is already low has completed its
                    // handshake, so each channel counts as done when its VALID
                    // is low or is being accepted right now.
                    if ((!AWVALID || AWREADY) && (!WVALID || WREADY)) begin
                        BREADY <= 1'b1;
                        state  <= WR_RESP;
                    end
                end

                WR_RESP: begin
                    if (BVALID) begin
                        BREADY    <= 1'b0;
                        rsp_valid <= 1'b1;
                        rsp_write <= 1'b1;
                        rsp_rdata <= '0;
                        rsp_resp  <= BRESP;
                        state     <= IDLE;
                    end
                end

                RD_ADDR: begin
                    if (ARREADY) begin
                        ARVALID <= 1'b0;
                        RREADY  <= 1'b1;
                        state   <= RD_DATA;
                    end
                end

                RD_DATA: begin
                    if (RVALID) begin
                        RREADY    <= 1'b0;
                        rsp_valid <= 1'b1;
                        rsp_write <= 1'b0;
                        rsp_rdata <= RDATA;
                        rsp_resp  <= RRESP;
                        state     <= IDLE;
                    end
                end

                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_axi4_lite_master.sv
// Bench for axi4_lite_master: a behavioural AXI4-Lite slave with per-channel
// wait counts, a timeline model that predicts every output from the accept
// cycle and the slave delays, and directed scenarios with literal checks.
`timescale 1ns/1ps
module tb_axi4_lite_master;

    localparam int DW = 32;
    localparam int AW = 32;
    localparam int SW = DW / 8;

    logic          ACLK;
    logic          ARESETn;
    logic          cmd_valid;
    logic          cmd_ready;
    logic          cmd_write;
    logic [AW-1:0] cmd_addr;
    logic [DW-1:0] cmd_wdata;
    logic [SW-1:0] cmd_wstrb;
    logic          rsp_valid;
    logic          rsp_write;
    logic [DW-1:0] rsp_rdata;
    logic [1:0]    rsp_resp;
    logic [AW-1:0] AWADDR;
    logic          AWVALID;
    logic          AWREADY;
    logic [DW-1:0] WDATA;
    logic [SW-1:0] WSTRB;
    logic          WVALID;
    logic          WREADY;
    logic [1:0]    BRESP;
    logic          BVALID;
    logic          BREADY;
    logic [AW-1:0] ARADDR;
    logic          ARVALID;
    logic          ARREADY;
    logic [DW-1:0] RDATA;
    logic [1:0]    RRESP;
    logic          RVALID;
    logic          RREADY;

    axi4_lite_master #(.DATA_WIDTH(DW), .ADDRESS_WIDTH(AW)) dut (
        .ACLK(ACLK), .ARESETn(ARESETn),
        .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_write(cmd_write),
        .cmd_addr(cmd_addr), .cmd_wdata(cmd_wdata), .cmd_wstrb(cmd_wstrb),
        .rsp_valid(rsp_valid), .rsp_write(rsp_write), .rsp_rdata(rsp_rdata),
        .rsp_resp(rsp_resp),
        .AWADDR(AWADDR), .AWVALID(AWVALID), .AWREADY(AWREADY),
        .WDATA(WDATA), .WSTRB(WSTRB), .WVALID(WVALID), .WREADY(WREADY),
        .BRESP(BRESP), .BVALID(BVALID), .BREADY(BREADY),
        .ARADDR(ARADDR), .ARVALID(ARVALID), .ARREADY(ARREADY),
        .RDATA(RDATA), .RRESP(RRESP), .RVALID(RVALID), .RREADY(RREADY)
    );

    initial ACLK = 1'b0;
    always #5 ACLK = ~ACLK;

    int cyc = 0;
    always @(posedge ACLK) cyc <= cyc + 1;

    int n_chk  = 0;
    int n_fail = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    function automatic bit in_win(input int k, input int lo, input int hi);
        return (k >= lo) && (k <= hi);
    endfunction

    // Slave configuration: cycles each READY/response waits after its trigger.
    int          aw_d = 0, w_d = 0, ar_d = 0, b_d = 0, r_d = 0;
    logic [1:0]  b_resp_cfg = 2'b00;
    logic [1:0]  r_resp_cfg = 2'b00;
    logic [31:0] r_data_cfg = 32'h0;
    bit          stray_b = 1'b0;

    // Behavioural slave, updated just after each rising edge.
    initial begin
        int aw_wait, w_wait, ar_wait, b_cnt, r_cnt;
        bit aw_got, w_got, ar_got, aw_fire, w_fire, ar_fire, b_fire, r_fire;
        aw_wait = 0; w_wait = 0; ar_wait = 0; b_cnt = 0; r_cnt = 0;
        aw_got = 0; w_got = 0; ar_got = 0;
        aw_fire = 0; w_fire = 0; ar_fire = 0; b_fire = 0; r_fire = 0;
        AWREADY = 0; WREADY = 0; ARREADY = 0; BVALID = 0; RVALID = 0;
        BRESP = 0; RRESP = 0; RDATA = 0;
        forever begin
            @(posedge ACLK);
            #1;
            if (!ARESETn) begin
                aw_wait = 0; w_wait = 0; ar_wait = 0; b_cnt = 0; r_cnt = 0;
                aw_got = 0; w_got = 0; ar_got = 0;
                aw_fire = 0; w_fire = 0; ar_fire = 0; b_fire = 0; r_fire = 0;
                AWREADY = 0; WREADY = 0; ARREADY = 0; BVALID = 0; RVALID = 0;
            end else begin
                if (aw_fire) aw_got = 1;
                if (w_fire)  w_got  = 1;
                if (ar_fire) ar_got = 1;
                if (b_fire) begin aw_got = 0; w_got = 0; b_cnt = 0; end
                if (r_fire) begin ar_got = 0; r_cnt = 0; end

                if (AWVALID) begin AWREADY = (aw_wait == aw_d); aw_wait++; end
                else begin AWREADY = 0; aw_wait = 0; end
                if (WVALID) begin WREADY = (w_wait == w_d); w_wait++; end
                else begin WREADY = 0; w_wait = 0; end
                if (ARVALID) begin ARREADY = (ar_wait == ar_d); ar_wait++; end
                else begin ARREADY = 0; ar_wait = 0; end

                if (aw_got && w_got) begin BVALID = (b_cnt >= b_d); b_cnt++; end
                else BVALID = stray_b;
                BRESP = b_resp_cfg;
                if (ar_got) begin RVALID = (r_cnt >= r_d); r_cnt++; end
                else RVALID = 0;
                RDATA = r_data_cfg;
                RRESP = r_resp_cfg;

                aw_fire = AWVALID && AWREADY;
                w_fire  = WVALID && WREADY;
                ar_fire = ARVALID && ARREADY;
                b_fire  = BVALID && BREADY && aw_got && w_got;
                r_fire  = RVALID && RREADY;
            end
        end
    end

    // Timeline model: for a command accepted in cycle c, each VALID/READY is
    // high over a window fixed by the slave delays, and the response strobe
    // lands the cycle after the final handshake.
    bit          m_busy = 0;
    bit          m_wr = 0;
    int          m_acc = 0, m_aw_end = 0, m_w_end = 0, m_b_beg = 0, m_b_end = 0;
    int          m_ar_end = 0, m_r_beg = 0, m_r_end = 0, m_rsp = 0;
    logic [31:0] m_awaddr = 0, m_wdata = 0, m_araddr = 0, m_rdata_pend = 0, m_rsp_rdata = 0;
    logic [3:0]  m_wstrb = 0;
    logic [1:0]  m_resp_pend = 0, m_rsp_resp = 0;
    logic        m_rsp_write = 0;
    logic        e_ready, e_awv, e_wv, e_bready, e_arv, e_rready, e_rsp;

    always @(negedge ACLK) begin
        if (!ARESETn) begin
            m_busy = 0; m_wr = 0;
            m_awaddr = 0; m_wdata = 0; m_wstrb = 0; m_araddr = 0;
            m_rsp_write = 0; m_rsp_rdata = 0; m_rsp_resp = 0;
        end else begin
            if (m_busy && cyc == m_rsp) begin
                m_rsp_write = m_wr;
                m_rsp_rdata = m_wr ? 32'h0 : m_rdata_pend;
                m_rsp_resp  = m_resp_pend;
            end
            e_ready  = !m_busy || (cyc >= m_rsp);
            e_awv    = m_busy && m_wr  && in_win(cyc, m_acc + 1, m_aw_end);
            e_wv     = m_busy && m_wr  && in_win(cyc, m_acc + 1, m_w_end);
            e_bready = m_busy && m_wr  && in_win(cyc, m_b_beg, m_b_end);
            e_arv    = m_busy && !m_wr && in_win(cyc, m_acc + 1, m_ar_end);
            e_rready = m_busy && !m_wr && in_win(cyc, m_r_beg, m_r_end);
            e_rsp    = m_busy && (cyc == m_rsp);

            chk("cmd_ready", 32'(cmd_ready), 32'(e_ready));
            chk("AWVALID",   32'(AWVALID),   32'(e_awv));
            chk("WVALID",    32'(WVALID),    32'(e_wv));
            chk("BREADY",    32'(BREADY),    32'(e_bready));
            chk("ARVALID",   32'(ARVALID),   32'(e_arv));
            chk("RREADY",    32'(RREADY),    32'(e_rready));
            chk("rsp_valid", 32'(rsp_valid), 32'(e_rsp));
            chk("rsp_write", 32'(rsp_write), 32'(m_rsp_write));
            chk("rsp_rdata", rsp_rdata,      m_rsp_rdata);
            chk("rsp_resp",  32'(rsp_resp),  32'(m_rsp_resp));
            chk("AWADDR",    AWADDR,         m_awaddr);
            chk("WDATA",     WDATA,          m_wdata);
            chk("WSTRB",     32'(WSTRB),     32'(m_wstrb));
            chk("ARADDR",    ARADDR,         m_araddr);

            if (m_busy && cyc >= m_rsp) m_busy = 0;
            if (cmd_valid && e_ready) begin
                m_busy = 1;
                m_acc  = cyc;
                m_wr   = cmd_write;
                if (cmd_write) begin
                    m_awaddr    = cmd_addr;
                    m_wdata     = cmd_wdata;
                    m_wstrb     = cmd_wstrb;
                    m_aw_end    = cyc + 1 + aw_d;
                    m_w_end     = cyc + 1 + w_d;
                    m_b_beg     = ((m_aw_end > m_w_end) ? m_aw_end : m_w_end) + 1;
                    m_b_end     = m_b_beg + b_d;
                    m_rsp       = m_b_end + 1;
                    m_rdata_pend = 32'h0;
                    m_resp_pend = b_resp_cfg;
                end else begin
                    m_araddr    = cmd_addr;
                    m_ar_end    = cyc + 1 + ar_d;
                    m_r_beg     = m_ar_end + 1;
                    m_r_end     = m_r_beg + r_d;
                    m_rsp       = m_r_end + 1;
                    m_rdata_pend = r_data_cfg;
                    m_resp_pend = r_resp_cfg;
                end
            end
        end
    end

    int acc_cyc = 0;
    int rsp_cyc = 0;

    // Present a command at the current time (just after a rising edge) and
    // return just after the edge that accepts it.
    task automatic do_cmd(input logic wr, input logic [31:0] addr, input logic [31:0] wd,
                          input logic [3:0] st, input bit keep);
        bit got;
        got = 0;
        cmd_write = wr; cmd_addr = addr; cmd_wdata = wd; cmd_wstrb = st; cmd_valid = 1;
        for (int i = 0; i < 100; i++) begin
            @(negedge ACLK);
            if (cmd_ready) begin got = 1; acc_cyc = cyc; break; end
        end
        chk("cmd accepted", 32'(got), 32'd1);
        @(posedge ACLK);
        #1;
        if (!keep) cmd_valid = 0;
    endtask

    task automatic wait_rsp;
        bit got;
        got = 0;
        for (int i = 0; i < 100; i++) begin
            @(negedge ACLK);
            if (rsp_valid) begin got = 1; rsp_cyc = cyc; break; end
        end
        chk("rsp seen", 32'(got), 32'd1);
    endtask

    initial begin
        int a1;
        ARESETn = 0;
        cmd_valid = 0; cmd_write = 0; cmd_addr = 0; cmd_wdata = 0; cmd_wstrb = 0;
        repeat (2) @(posedge ACLK);
        #3;
        chk("reset cmd_ready", 32'(cmd_ready), 32'd1);
        chk("reset AWVALID",   32'(AWVALID),   32'd0);
        chk("reset WVALID",    32'(WVALID),    32'd0);
        chk("reset ARVALID",   32'(ARVALID),   32'd0);
        chk("reset BREADY",    32'(BREADY),    32'd0);
        chk("reset RREADY",    32'(RREADY),    32'd0);
        chk("reset rsp_valid", 32'(rsp_valid), 32'd0);
        chk("reset rsp_rdata", rsp_rdata,      32'd0);
        chk("reset AWADDR",    AWADDR,         32'd0);
        ARESETn = 1;
        @(posedge ACLK);
        #1;

        // Zero-wait write: strobe on the fourth cycle counting the accept cycle.
        do_cmd(1'b1, 32'h10, 32'hDEADBEEF, 4'hF, 0);
        chk("t1 AWADDR", AWADDR, 32'h10);
        chk("t1 WDATA",  WDATA,  32'hDEADBEEF);
        wait_rsp();
        chk("t1 latency",   32'(rsp_cyc - acc_cyc), 32'd3);
        chk("t1 rsp_write", 32'(rsp_write), 32'd1);
        chk("t1 rsp_resp",  32'(rsp_resp),  32'd0);
        @(posedge ACLK);
        #1;

        // Read with ARREADY held off for 3 cycles.
        ar_d = 3; r_data_cfg = 32'hCAFEF00D; r_resp_cfg = 2'd2;
        do_cmd(1'b0, 32'h44, 32'h0, 4'h0, 0);
        wait_rsp();
        chk("t2 latency",   32'(rsp_cyc - acc_cyc), 32'd6);
        chk("t2 rsp_rdata", rsp_rdata, 32'hCAFEF00D);
        chk("t2 rsp_resp",  32'(rsp_resp),  32'd2);
        chk("t2 rsp_write", 32'(rsp_write), 32'd0);
        @(negedge ACLK);
        chk("t2 strobe one cycle", 32'(rsp_valid), 32'd0);
        chk("t2 rdata held",       rsp_rdata, 32'hCAFEF00D);
        @(posedge ACLK);
        #1;

        // W accepted two cycles before AW.
        ar_d = 0; aw_d = 2; w_d = 0; b_resp_cfg = 2'd1;
        do_cmd(1'b1, 32'h20, 32'h12345678, 4'h3, 0);
        wait_rsp();
        chk("t3 latency",  32'(rsp_cyc - acc_cyc), 32'd5);
        chk("t3 rsp_resp", 32'(rsp_resp), 32'd1);
        @(posedge ACLK);
        #1;

        // AW accepted two cycles before W; unaligned address, no strobes.
        aw_d = 0; w_d = 2; b_resp_cfg = 2'd0;
        do_cmd(1'b1, 32'h13, 32'hA5A55A5A, 4'h0, 0);
        wait_rsp();
        chk("t4 latency", 32'(rsp_cyc - acc_cyc), 32'd5);
        @(posedge ACLK);
        #1;

        // Back-to-back write then read with cmd_valid held.
        w_d = 0; r_data_cfg = 32'h0BADF00D; r_resp_cfg = 2'd0;
        do_cmd(1'b1, 32'h30, 32'h11112222, 4'hF, 1);
        a1 = acc_cyc;
        do_cmd(1'b0, 32'h34, 32'h0, 4'h0, 0);
        chk("t5 accept spacing", 32'(acc_cyc - a1), 32'd3);
        wait_rsp();
        chk("t5 latency",   32'(rsp_cyc - acc_cyc), 32'd3);
        chk("t5 rsp_rdata", rsp_rdata, 32'h0BADF00D);
        @(posedge ACLK);
        #1;

        // Stray BVALID throughout a read.
        r_d = 3; stray_b = 1; r_data_cfg = 32'h5555AAAA;
        do_cmd(1'b0, 32'h40, 32'h0, 4'h0, 0);
        wait_rsp();
        chk("t6 latency",   32'(rsp_cyc - acc_cyc), 32'd6);
        chk("t6 rsp_rdata", rsp_rdata, 32'h5555AAAA);
        chk("t6 BREADY",    32'(BREADY), 32'd0);
        stray_b = 0;
        r_d = 0;
        @(posedge ACLK);
        #1;

        // Reset pulse while waiting on BVALID, then a clean read.
        b_d = 5;
        do_cmd(1'b1, 32'h60, 32'h77778888, 4'hF, 0);
        repeat (3) @(negedge ACLK);
        chk("t7 in WR_RESP", 32'(BREADY), 32'd1);
        #2;
        ARESETn = 0;
        #1;
        chk("t7 rst AWVALID",   32'(AWVALID),   32'd0);
        chk("t7 rst WVALID",    32'(WVALID),    32'd0);
        chk("t7 rst BREADY",    32'(BREADY),    32'd0);
        chk("t7 rst rsp_valid", 32'(rsp_valid), 32'd0);
        repeat (2) @(posedge ACLK);
        #3;
        ARESETn = 1;
        b_d = 0;
        chk("t7 cmd_ready", 32'(cmd_ready), 32'd1);
        chk("t7 rsp_rdata", rsp_rdata, 32'd0);
        @(posedge ACLK);
        #1;
        r_data_cfg = 32'h600DCAFE;
        do_cmd(1'b0, 32'h50, 32'h0, 4'h0, 0);
        wait_rsp();
        chk("t7 latency",   32'(rsp_cyc - acc_cyc), 32'd3);
        chk("t7 rsp_rdata", rsp_rdata, 32'h600DCAFE);

        repeat (3) @(posedge ACLK);
        #1;
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
